// File: rtl/ula_seq_resp.sv
// Handshaked sequential 74181 responder: one 4-bit slice per cycle, low nibble first.
// Define ULA_SEQ_RESP_ONECYCLE_EN to ripple all slices combinationally in a single CALC cycle.
module ula_seq_resp #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   s,
    input  logic         m,
    input  logic         c_in,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] f,
    output logic         c_out,
    output logic         a_eq_b,
    output logic         busy
);

    localparam int NIB = W / 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [3:0]   s_q, s_d;
    logic         m_q, m_d;
    logic         carry_q, carry_d;
    logic [W-1:0] f_q, f_d;
    logic         c_out_q, c_out_d;
    logic         a_eq_b_q, a_eq_b_d;
    logic [4:0]   slice_out;

`ifdef ULA_SEQ_RESP_ONECYCLE_EN
    logic         chain_c;
    logic         chain_eq;
`else
    localparam int NCW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [NCW-1:0] LAST_NIB = NCW'(NIB - 1);

    logic [NCW-1:0] nib_cnt_q, nib_cnt_d;
    logic           eq_acc_q, eq_acc_d;
    int unsigned    nib_idx;
`endif

    // One active-high 74181 slice: returns {Cn+4 (active-low), F}.
    // Arithmetic F is the sum of the two internal operand terms; logic F is their XNOR.
    function automatic logic [4:0] slice181(
        input logic [3:0] sa,
        input logic [3:0] sb,
        input logic [3:0] sel,
        input logic       mode,
        input logic       cn_n
    );
        logic [3:0] t1;
        logic [3:0] t2;
        logic [4:0] sum;
        t1  = sa | (sb & {4{sel[0]}}) | (~sb & {4{sel[1]}});
        t2  = (sa & ~sb & {4{sel[2]}}) | (sa & sb & {4{sel[3]}});
        sum = {1'b0, t1} + {1'b0, t2} + {4'b0000, ~cn_n};
        slice181 = {~sum[4], (mode ? ~(t1 ^ t2) : sum[3:0])};
    endfunction

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        m_d       = m_q;
        carry_d   = carry_q;
        f_d       = f_q;
        c_out_d   = c_out_q;
        a_eq_b_d  = a_eq_b_q;
        slice_out = '0;
`ifdef ULA_SEQ_RESP_ONECYCLE_EN
        chain_c   = carry_q;
        chain_eq  = 1'b1;
`else
        nib_cnt_d = nib_cnt_q;
        eq_acc_d  = eq_acc_q;
        nib_idx   = 0;
`endif

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d     = a;
                    b_d     = b;
                    s_d     = s;
                    m_d     = m;
                    carry_d = c_in;
`ifndef ULA_SEQ_RESP_ONECYCLE_EN
                    nib_cnt_d = '0;
                    eq_acc_d  = 1'b1;
`endif
                    state_d = CALC;
                end
            end

            CALC: begin
`ifdef ULA_SEQ_RESP_ONECYCLE_EN
                for (int unsigned i = 0; i < NIB; i++) begin
                    slice_out       = slice181(a_q[4*i +: 4], b_q[4*i +: 4], s_q, m_q, chain_c);
                    f_d[4*i +: 4]   = slice_out[3:0];
                    chain_c         = slice_out[4];
                    chain_eq        = chain_eq & (&slice_out[3:0]);
                end
                carry_d  = chain_c;
                c_out_d  = chain_c;
                a_eq_b_d = chain_eq;
                state_d  = DONE;
`else
                nib_idx             = int'(nib_cnt_q);
                slice_out           = slice181(a_q[4*nib_idx +: 4], b_q[4*nib_idx +: 4],
                                               s_q, m_q, carry_q);
                f_d[4*nib_idx +: 4] = slice_out[3:0];
                carry_d             = slice_out[4];
                eq_acc_d            = eq_acc_q & (&slice_out[3:0]);
                // c_out/a_eq_b only move on the final nibble so they hold the old result meanwhile
                if (nib_cnt_q == LAST_NIB) begin
                    c_out_d  = slice_out[4];
                    a_eq_b_d = eq_acc_d;
                    state_d  = DONE;
                end else begin
                    nib_cnt_d = nib_cnt_q + 1'b1;
                end
`endif
            end

            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            m_q       <= 1'b0;
            carry_q   <= 1'b0;
            f_q       <= '0;
            c_out_q   <= 1'b1;
            a_eq_b_q  <= 1'b0;
`ifndef ULA_SEQ_RESP_ONECYCLE_EN
            nib_cnt_q <= '0;
            eq_acc_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            s_q       <= s_d;
            m_q       <= m_d;
            carry_q   <= carry_d;
            f_q       <= f_d;
            c_out_q   <= c_out_d;
            a_eq_b_q  <= a_eq_b_d;
`ifndef ULA_SEQ_RESP_ONECYCLE_EN
            nib_cnt_q <= nib_cnt_d;
            eq_acc_q  <= eq_acc_d;
`endif
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign f         = f_q;
    assign c_out     = c_out_q;
    assign a_eq_b    = a_eq_b_q;

endmodule

// File: tb/tb_ula_seq_resp.sv
// Bench for ula_seq_resp: datasheet-level 74181 model plus a handshake timing model,
// checked every cycle, with directed literal cases and random traffic.
module tb_ula_seq_resp;

    localparam int W = 8;
`ifdef ULA_SEQ_RESP_ONECYCLE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = W / 4;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   s = '0;
    logic         m = 1'b0;
    logic         c_in = 1'b1;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] f;
    logic         c_out;
    logic         a_eq_b;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    ula_seq_resp #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a         (a),
        .b         (b),
        .s         (s),
        .m         (m),
        .c_in      (c_in),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .f         (f),
        .c_out     (c_out),
        .a_eq_b    (a_eq_b),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Datasheet function table over the full width: {a_eq_b, c_out, f}.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input logic [3:0] rs, input logic rm, input logic rc);
        logic [W-1:0] x, y, lg, ones, rf;
        logic [W:0]   sum;
        ones = '1;
        case (rs)
            4'h0: begin x = ra;       y = '0;       lg = ~ra;        end
            4'h1: begin x = ra | rb;  y = '0;       lg = ~(ra | rb); end
            4'h2: begin x = ra | ~rb; y = '0;       lg = ~ra & rb;   end
            4'h3: begin x = ones;     y = '0;       lg = '0;         end
            4'h4: begin x = ra;       y = ra & ~rb; lg = ~(ra & rb); end
            4'h5: begin x = ra | rb;  y = ra & ~rb; lg = ~rb;        end
            4'h6: begin x = ra;       y = ~rb;      lg = ra ^ rb;    end
            4'h7: begin x = ra & ~rb; y = ones;     lg = ra & ~rb;   end
            4'h8: begin x = ra;       y = ra & rb;  lg = ~ra | rb;   end
            4'h9: begin x = ra;       y = rb;       lg = ~(ra ^ rb); end
            4'hA: begin x = ra | ~rb; y = ra & rb;  lg = rb;         end
            4'hB: begin x = ra & rb;  y = ones;     lg = ra & rb;    end
            4'hC: begin x = ra;       y = ra;       lg = ones;       end
            4'hD: begin x = ra | rb;  y = ra;       lg = ra | ~rb;   end
            4'hE: begin x = ra | ~rb; y = ra;       lg = ra | rb;    end
            default: begin x = ra;    y = ones;     lg = ra;         end
        endcase
        sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ~rc};
        rf  = rm ? lg : sum[W-1:0];
        return {(rf == ones), ~sum[W], rf};
    endfunction

    // Handshake model: 0 idle, 1 computing, 2 result presented
    int           m_phase = 0;
    int           m_left  = 0;
    logic [W+1:0] pend    = '0;
    logic [W-1:0] exp_f   = '0;
    logic         exp_c   = 1'b1;
    logic         exp_eq  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_left  <= 0;
            exp_f   <= '0;
            exp_c   <= 1'b1;
            exp_eq  <= 1'b0;
        end else begin
            case (m_phase)
                0: if (req_valid) begin
                    pend    <= ref_op(a, b, s, m, c_in);
                    m_left  <= LAT - 1;
                    m_phase <= 1;
                end
                1: if (m_left == 0) begin
                    exp_f   <= pend[W-1:0];
                    exp_c   <= pend[W];
                    exp_eq  <= pend[W+1];
                    m_phase <= 2;
                end else begin
                    m_left <= m_left - 1;
                end
                default: if (rsp_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("req_ready", req_ready, m_phase == 0);
            check("busy", busy, m_phase != 0);
            check("rsp_valid", rsp_valid, m_phase == 2);
            if (m_phase != 1) begin
                check("f", f, exp_f);
                check("c_out", c_out, exp_c);
                check("a_eq_b", a_eq_b, exp_eq);
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic [3:0] ts,
                          input logic tm, input logic tc, input int hold,
                          output logic [W-1:0] rf, output logic rc, output logic req_o,
                          output int lat);
        int n;
        a = ta; b = tbv; s = ts; m = tm; c_in = tc;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_wait", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rf = f; rc = c_out; req_o = a_eq_b;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic random_traffic(input int cycles, input bit always_busy);
        bit last_rdy;
        last_rdy = req_ready;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            // a pending, unaccepted request keeps its operands
            if (!(req_valid && !last_rdy)) begin
                req_valid = always_busy ? 1'b1 : ($urandom_range(0, 1) == 1);
                a    = W'($urandom);
                b    = W'($urandom);
                s    = 4'($urandom);
                m    = 1'($urandom);
                c_in = 1'($urandom);
            end
            rsp_ready = always_busy ? 1'b1 : ($urandom_range(0, 3) != 0);
            last_rdy  = req_ready;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (W / 4 + 4) begin
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rf;
        logic         rc, req_o;
        logic [W+1:0] r;
        int           lat, n;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_f", f, 8'h00);
        check("rst_c_out", c_out, 1'b1);
        check("rst_a_eq_b", a_eq_b, 1'b0);
        rst = 1'b0;

        r = ref_op(8'hFF, 8'h00, 4'b0000, 1'b0, 1'b0);
        check("model_a_plus_1", r, {1'b0, 1'b0, 8'h00});
        r = ref_op(8'h3C, 8'h05, 4'b1001, 1'b0, 1'b1);
        check("model_a_plus_b", r, {1'b0, 1'b1, 8'h41});
        r = ref_op(8'h05, 8'h05, 4'b0110, 1'b0, 1'b1);
        check("model_a_minus_b_minus_1", r, {1'b1, 1'b1, 8'hFF});
        r = ref_op(8'hAA, 8'h0F, 4'b0110, 1'b1, 1'b0);
        check("model_xor", r, {1'b0, 1'b0, 8'hA5});

        @(posedge clk); #1;
        run_op(8'hFF, 8'h00, 4'b0000, 1'b0, 1'b0, 0, rf, rc, req_o, lat);
        check("t1_f", rf, 8'h00);
        check("t1_c_out", rc, 1'b0);
        check("t1_a_eq_b", req_o, 1'b0);
        check("t1_latency", lat, LAT);

        run_op(8'h3C, 8'h05, 4'b1001, 1'b0, 1'b1, 1, rf, rc, req_o, lat);
        check("t2_f", rf, 8'h41);
        check("t2_c_out", rc, 1'b1);

        run_op(8'h05, 8'h05, 4'b0110, 1'b0, 1'b1, 0, rf, rc, req_o, lat);
        check("t3_f", rf, 8'hFF);
        check("t3_a_eq_b", req_o, 1'b1);
        check("t3_c_out", rc, 1'b1);

        run_op(8'hAA, 8'h0F, 4'b0110, 1'b1, 1'b0, 0, rf, rc, req_o, lat);
        check("t4_f_cin0", rf, 8'hA5);
        run_op(8'hAA, 8'h0F, 4'b0110, 1'b1, 1'b1, 0, rf, rc, req_o, lat);
        check("t4_f_cin1", rf, 8'hA5);

        // Back-pressure: second request waits through a stalled DONE
        a = 8'h3C; b = 8'h05; s = 4'b1001; m = 1'b0; c_in = 1'b1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        a = 8'hFF; b = 8'h00; s = 4'b0000; m = 1'b0; c_in = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_first_f", f, 8'h41);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t5_hold_rsp_valid", rsp_valid, 1'b1);
            check("t5_hold_req_ready", req_ready, 1'b0);
            check("t5_hold_f", f, 8'h41);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("t5_release_rsp_valid", rsp_valid, 1'b0);
        check("t5_release_req_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("t5_second_accepted", busy, 1'b1);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_second_f", f, 8'h00);
        check("t5_second_c_out", c_out, 1'b0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Asynchronous reset in the middle of a computation
        a = 8'hAA; b = 8'h0F; s = 4'b0110; m = 1'b1; c_in = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_rsp_valid", rsp_valid, 1'b0);
        check("t6_rst_req_ready", req_ready, 1'b1);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_f", f, 8'h00);
        check("t6_rst_c_out", c_out, 1'b1);
        check("t6_rst_a_eq_b", a_eq_b, 1'b0);
        @(posedge clk); #1;
        check("t6_rst_no_rsp", rsp_valid, 1'b0);
        rst = 1'b0;
        run_op(8'h3C, 8'h05, 4'b1001, 1'b0, 1'b1, 0, rf, rc, req_o, lat);
        check("t6_after_f", rf, 8'h41);
        check("t6_after_latency", lat, LAT);

        random_traffic(1500, 1'b0);
        random_traffic(400, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
